// File: rtl/vc_pop_scheduler_if.sv
// Bus bundle between the two VC FIFOs, the destination pause inputs and vc_pop_scheduler.
// The master modport is the scheduler side.
interface vc_pop_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 6
);
  logic                  vc0_empty;
  logic                  vc1_empty;
  logic [DATA_WIDTH-1:0] vc0_data;
  logic [DATA_WIDTH-1:0] vc1_data;
  logic                  pause_d0;
  logic                  pause_d1;
  logic                  pop_vc0;
  logic                  pop_vc1;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  push_d0;
  logic                  push_d1;
  logic [1:0]            grant_state;

  modport master (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data, pause_d0, pause_d1,
    output pop_vc0, pop_vc1, data_out, push_d0, push_d1, grant_state
  );

  modport slave (
    output vc0_empty, vc1_empty, vc0_data, vc1_data, pause_d0, pause_d1,
    input  pop_vc0, pop_vc1, data_out, push_d0, push_d1, grant_state
  );
endinterface

// File: rtl/vc_pop_scheduler.sv
// Weighted round-robin drain of VC0/VC1 first-word-fall-through FIFOs into one
// registered output, steered to d0/d1 by the word MSB.
// Optional grant statistics: define SCHED_STATS_EN.
module vc_pop_scheduler #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned VC0_WEIGHT = 3
) (
  input  logic               clk,
  input  logic               reset_L,
  vc_pop_scheduler_if.master bus
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]        gnt_cnt_vc0,
  output logic [15:0]        gnt_cnt_vc1
`endif
);
  localparam int unsigned    MSB    = DATA_WIDTH - 1;
  localparam logic [3:0]     WEIGHT = 4'(VC0_WEIGHT);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LAST_VC0 = 2'b01,
    LAST_VC1 = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  push_d0_q, push_d0_d;
  logic                  push_d1_q, push_d1_d;
  logic                  elig0, elig1;
  logic                  gnt0, gnt1;
  logic [DATA_WIDTH-1:0] gnt_word;

  // Per-destination eligibility: a paused destination blocks only the VC whose head targets it.
  always_comb begin
    elig0 = !bus.vc0_empty && !(bus.vc0_data[MSB] ? bus.pause_d1 : bus.pause_d0);
    elig1 = !bus.vc1_empty && !(bus.vc1_data[MSB] ? bus.pause_d1 : bus.pause_d0);
  end

  // Weighted arbitration; no grant at all while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_L) begin
      if (elig0 && elig1) begin
        if (cnt_q < WEIGHT) gnt0 = 1'b1;
        else                gnt1 = 1'b1;
      end else if (elig0) begin
        gnt0 = 1'b1;
      end else if (elig1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Next state: weight counter, observational FSM and output register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    push_d0_d = 1'b0;
    push_d1_d = 1'b0;
    gnt_word  = gnt1 ? bus.vc1_data : bus.vc0_data;
    if (gnt0) begin
      state_d = LAST_VC0;
      if (elig1 && (cnt_q < WEIGHT)) cnt_d = cnt_q + 4'd1;
    end else if (gnt1) begin
      state_d = LAST_VC1;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
    end
    if (gnt0 || gnt1) begin
      data_d    = gnt_word;
      push_d0_d = !gnt_word[MSB];
      push_d1_d = gnt_word[MSB];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      push_d0_q <= push_d0_d;
      push_d1_q <= push_d1_d;
    end
  end

  assign bus.pop_vc0     = gnt0;
  assign bus.pop_vc1     = gnt1;
  assign bus.data_out    = data_q;
  assign bus.push_d0     = push_d0_q;
  assign bus.push_d1     = push_d1_q;
  assign bus.grant_state = state_q;

`ifdef SCHED_STATS_EN
  logic [15:0] gnt_cnt_vc0_q, gnt_cnt_vc0_d;
  logic [15:0] gnt_cnt_vc1_q, gnt_cnt_vc1_d;

  // Free-running grant counters, wrapping at 16 bits.
  always_comb begin
    gnt_cnt_vc0_d = gnt_cnt_vc0_q + {15'd0, gnt0};
    gnt_cnt_vc1_d = gnt_cnt_vc1_q + {15'd0, gnt1};
  end

  // Grant counter registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      gnt_cnt_vc0_q <= '0;
      gnt_cnt_vc1_q <= '0;
    end else begin
      gnt_cnt_vc0_q <= gnt_cnt_vc0_d;
      gnt_cnt_vc1_q <= gnt_cnt_vc1_d;
    end
  end

  assign gnt_cnt_vc0 = gnt_cnt_vc0_q;
  assign gnt_cnt_vc1 = gnt_cnt_vc1_q;
`endif
endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Directed scoreboard bench for vc_pop_scheduler (VC0_WEIGHT = 3, DATA_WIDTH = 6).
module tb_vc_pop_scheduler;
  localparam int unsigned DW = 6;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          p0;
    logic          p1;
    logic [1:0]    st;
  } exp_t;

  logic          clk;
  logic          reset_L;
  logic [DW-1:0] f0[$];
  logic [DW-1:0] f1[$];
  exp_t          sb[$];
  logic [DW-1:0] last_word;
  int            n_cmp;
  int            n_err;
  int            n0;
  int            n1;

  vc_pop_scheduler_if #(.DATA_WIDTH(DW)) bus ();

`ifdef SCHED_STATS_EN
  logic [15:0] gnt_cnt_vc0;
  logic [15:0] gnt_cnt_vc1;
`endif

  vc_pop_scheduler #(
    .DATA_WIDTH(DW),
    .VC0_WEIGHT(3)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .bus        (bus)
`ifdef SCHED_STATS_EN
    ,
    .gnt_cnt_vc0(gnt_cnt_vc0),
    .gnt_cnt_vc1(gnt_cnt_vc1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.vc0_empty = (f0.size() == 0);
    bus.vc1_empty = (f1.size() == 0);
    bus.vc0_data  = (f0.size() != 0) ? f0[0] : '0;
    bus.vc1_data  = (f1.size() != 0) ? f1[0] : '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pop_vc0"},  16'(bus.pop_vc0), 16'd0);
    check({tag, "_pop_vc1"},  16'(bus.pop_vc1), 16'd0);
    check({tag, "_data_out"}, 16'(bus.data_out), 16'd0);
    check({tag, "_push_d0"},  16'(bus.push_d0), 16'd0);
    check({tag, "_push_d1"},  16'(bus.push_d1), 16'd0);
    check({tag, "_state"},    16'(bus.grant_state), 16'd0);
  endtask

  // g: 0 = VC0 grant expected, 1 = VC1 grant expected, -1 = no grant expected.
  task automatic cycle(input int g);
    exp_t e;
    logic s0;
    logic s1;
    @(negedge clk);
    s0 = bus.pop_vc0;
    s1 = bus.pop_vc1;
    check("pop_vc0", 16'(s0), 16'(g == 0));
    check("pop_vc1", 16'(s1), 16'(g == 1));
    e.d  = last_word;
    e.p0 = 1'b0;
    e.p1 = 1'b0;
    e.st = 2'b00;
    if (g == 0) begin
      e.d  = f0[0];
      e.st = 2'b01;
      n0++;
    end else if (g == 1) begin
      e.d  = f1[0];
      e.st = 2'b10;
      n1++;
    end
    if (g >= 0) begin
      e.p0      = !e.d[DW-1];
      e.p1      = e.d[DW-1];
      last_word = e.d;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (s0 && f0.size() != 0) void'(f0.pop_front());
    if (s1 && f1.size() != 0) void'(f1.pop_front());
    drive();
    e = sb.pop_front();
    check("data_out",    16'(bus.data_out),    16'(e.d));
    check("push_d0",     16'(bus.push_d0),     16'(e.p0));
    check("push_d1",     16'(bus.push_d1),     16'(e.p1));
    check("grant_state", 16'(bus.grant_state), 16'(e.st));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    n0        = 0;
    n1        = 0;
    last_word = '0;
    reset_L   = 1'b0;
    bus.pause_d0 = 1'b0;
    bus.pause_d1 = 1'b0;

    // Reset with both FIFOs loaded: weighting data, all to d0.
    for (int i = 0; i < 12; i++) f0.push_back(DW'(i + 1));
    for (int i = 0; i < 4; i++)  f1.push_back(DW'(16 + i));
    drive();
    #2;
    check_idle_outputs("rst_async");
    @(posedge clk);
    #1;
    check_idle_outputs("rst_clocked");
    reset_L = 1'b1;

    // Weighting: VC0,VC0,VC0,VC1 repeating.
    for (int r = 0; r < 4; r++) begin
      cycle(0); cycle(0); cycle(0); cycle(1);
    end
    cycle(-1);

    // VC0 head to paused d1 blocks only VC0.
    bus.pause_d1 = 1'b1;
    for (int i = 0; i < 3; i++) f0.push_back(DW'(6'h21 + i));
    for (int i = 0; i < 3; i++) f1.push_back(DW'(6'h04 + i));
    drive();
    cycle(1); cycle(1); cycle(1); cycle(-1);
    // Counter stayed at 0: full weight of VC0 grants again.
    bus.pause_d1 = 1'b0;
    for (int i = 0; i < 4; i++) f1.push_back(DW'(6'h07 + i));
    drive();
    cycle(0); cycle(0); cycle(0); cycle(1);
    cycle(1); cycle(1); cycle(1); cycle(-1);

    // Single VC: counter must not advance while VC1 is ineligible.
    for (int i = 0; i < 5; i++) f0.push_back(DW'(6'h0b + i));
    drive();
    for (int i = 0; i < 5; i++) cycle(0);
    cycle(-1);
    for (int i = 0; i < 4; i++) f0.push_back(DW'(6'h01 + i));
    for (int i = 0; i < 2; i++) f1.push_back(DW'(6'h30 + i));
    drive();
    cycle(0); cycle(0); cycle(0); cycle(1); cycle(0); cycle(1); cycle(-1);

    // Both destinations paused mid-stream.
    for (int i = 0; i < 4; i++) f0.push_back(DW'(6'h08 + i));
    for (int i = 0; i < 4; i++) f1.push_back(DW'(6'h38 + i));
    drive();
    cycle(0); cycle(0);
    bus.pause_d0 = 1'b1;
    bus.pause_d1 = 1'b1;
    cycle(-1); cycle(-1);
    bus.pause_d0 = 1'b0;
    bus.pause_d1 = 1'b0;
    cycle(0); cycle(1); cycle(0); cycle(1); cycle(1); cycle(1); cycle(-1);

    // Reset mid-burst: registered word discarded, no pop during reset.
    for (int i = 0; i < 3; i++) f0.push_back(DW'(6'h12 + i));
    drive();
    cycle(0);
    @(negedge clk);
    check("midrst_pop_before", 16'(bus.pop_vc0), 16'd1);
    reset_L = 1'b0;
    #1;
    check_idle_outputs("midrst_async");
    @(posedge clk);
    #1;
    check_idle_outputs("midrst_clocked");
    reset_L   = 1'b1;
    last_word = '0;
    n0        = 0;
    n1        = 0;
    cycle(0); cycle(0); cycle(-1);

`ifdef SCHED_STATS_EN
    check("stats_vc0_pre", gnt_cnt_vc0, 16'(n0));
    check("stats_vc1_pre", gnt_cnt_vc1, 16'(n1));
    bus.vc0_empty = 1'b0;
    bus.vc0_data  = DW'(6'h05);
    bus.vc1_empty = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    f0.delete();
    f1.delete();
    drive();
    check("stats_vc0_wrap", gnt_cnt_vc0, 16'(n0));
    check("stats_vc1_hold", gnt_cnt_vc1, 16'(n1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vc_pop_scheduler.md
# vc_pop_scheduler

Weighted round-robin scheduler that drains the two virtual-channel FIFOs (VC0, VC1) into the single shared output path of the interconnect device, one word per cycle. Eligibility is per destination: a VC is served only when its first-word-fall-through FIFO holds a word and that word's destination (d0/d1) is not paused. Output words are registered and steered to the d0 or d1 push strobe.

## Interface
Parameters:
- DATA_WIDTH, 6, word width; bit DATA_WIDTH-1 is the destination select (0 = d0, 1 = d1)
- VC0_WEIGHT, 3, consecutive VC0 grants allowed while VC1 is also eligible before VC1 must be granted (range 1..15)

Ports:
- clk  input  1  single clock, all state on rising edge
- reset_L  input  1  asynchronous, active-low reset
- vc0_empty  input  1  VC0 FIFO empty
- vc1_empty  input  1  VC1 FIFO empty
- vc0_data  input  DATA_WIDTH  VC0 FIFO head word, valid whenever vc0_empty=0
- vc1_data  input  DATA_WIDTH  VC1 FIFO head word, valid whenever vc1_empty=0
- pause_d0  input  1  destination d0 almost-full; no new word to d0
- pause_d1  input  1  destination d1 almost-full; no new word to d1
- pop_vc0  output  1  combinational pop of VC0 head this cycle
- pop_vc1  output  1  combinational pop of VC1 head this cycle
- data_out  output  DATA_WIDTH  registered popped word
- push_d0  output  1  registered; data_out is written to d0
- push_d1  output  1  registered; data_out is written to d1
- grant_state  output  2  registered FSM state (00 IDLE, 01 LAST_VC0, 10 LAST_VC1)

## Operation
- elig0 = !vc0_empty && !(vc0_data[MSB] ? pause_d1 : pause_d0); elig1 likewise for VC1.
- At most one of pop_vc0/pop_vc1 high per cycle; never pop a non-eligible VC.
- Arbitration (combinational, from registered state and weight counter cnt, 4 bits):
  - only elig0 -> grant VC0; only elig1 -> grant VC1; neither -> no pop.
  - both: grant VC0 if cnt < VC0_WEIGHT, else grant VC1.
- cnt update: VC0 grant while elig1=1 -> cnt+1 (saturates at VC0_WEIGHT); VC0 grant while elig1=0 -> unchanged; any VC1 grant -> 0; no grant -> unchanged.
- FSM: IDLE -> LAST_VC0 on VC0 grant, -> LAST_VC1 on VC1 grant; LAST_x -> IDLE on a cycle with no grant; LAST_VC0 <-> LAST_VC1 on the corresponding grant. State is observational; arbitration depends only on cnt and eligibility.
- Output register: on a grant, data_out <= granted head word; push_d0 <= (dest bit == 0), push_d1 <= (dest bit == 1). No grant -> push_d0 = push_d1 = 0, data_out holds.
- Head-of-line: a VC whose head targets a paused destination blocks only that VC; the other VC keeps draining.

## Timing
- Reset (async assert, sync deassert handled upstream): data_out=0, push_d0=0, push_d1=0, grant_state=IDLE, cnt=0, stats counters=0. pop_vc0/pop_vc1 forced 0 while reset_L=0.
- pop asserted in cycle N -> push_dx/data_out valid in cycle N+1; latency 1.
- Pause is sampled the same cycle as pop; destination must assert pause with >=1 free entry of margin for the in-flight word.
- Throughput: 1 word/cycle with any eligible VC.
- Both pauses high -> no pops; push strobes drop to 0 the following cycle.
- Reset mid-burst: in-flight registered word discarded; no pop during reset.

## Configuration
- SCHED_STATS_EN defined: adds outputs gnt_cnt_vc0 and gnt_cnt_vc1 (16 bits each), incremented on each grant of the respective VC, wrapping 0xFFFF -> 0, cleared by reset.
- Undefined: those ports and counters do not exist; all other behaviour identical.

## Test plan
- Reset: reset_L=0 with both FIFOs non-empty -> pops 0, all outputs 0, grant_state=00; release -> first pop next edge.
- Weighting, VC0_WEIGHT=3, both FIFOs full, no pause, dests d0 -> grant order VC0,VC0,VC0,VC1 repeating; push_d0=1 every cycle from cycle 2.
- Per-destination pause: VC0 head dest d1, VC1 head dest d0, pause_d1=1 -> only pop_vc1 each cycle, push_d0=1, cnt stays 0.
- Single VC: vc1_empty=1, 5 VC0 words -> 5 consecutive VC0 pops, cnt unchanged at 0, FSM IDLE->LAST_VC0->IDLE after last word.
- Both paused: pause_d0=pause_d1=1 mid-stream -> pops stop same cycle, push strobes 0 next cycle, data_out holds last word.
- With SCHED_STATS_EN: 0x10000 VC0 grants -> gnt_cnt_vc0 wraps to 0; gnt_cnt_vc1 unaffected.
